// File: rtl/div_iter_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package div_iter_pkg;

    localparam int DIV_XLEN_DEF  = 32;
    localparam int DIV_CNT_W_DEF = 6;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring division step: shift {rem,quo} left, subtract divisor, restore on borrow.
module div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shl;
    logic [XLEN:0] trial;

    // rem < div always holds, so the shifted partial remainder needs one extra bit
    assign shl   = {rem_i, quo_i[XLEN-1]};
    assign trial = shl - {1'b0, div_i};

    always_comb begin
        rem_o = shl[XLEN-1:0];
        quo_o = {quo_i[XLEN-2:0], 1'b0};
        if (!trial[XLEN]) begin
            rem_o = trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_iter.sv
// Unsigned iterative divider behind a level req / pulse ready handshake; XLEN steps per divide.
module div_iter
    import div_iter_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN_DEF,
    parameter int CNT_W = DIV_CNT_W_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            is_q_i,
    output logic            ready_o,
    output logic [XLEN-1:0] result_o
);

    div_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] div_q, div_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            sel_q, sel_d;
    logic [XLEN-1:0] rem_n, quo_n;

    div_iter_step #(.XLEN(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (div_q),
        .rem_o (rem_n),
        .quo_o (quo_n)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        div_d    = div_q;
        sel_d    = sel_q;
        result_d = result_q;
        case (state_q)
            DIV_IDLE: begin
                if (req_i) begin
                    sel_d = is_q_i;
                    div_d = b_i;
                    cnt_d = '0;
                    if (b_i == '0) begin
                        // divide-by-zero: RISC-V M results, no iteration
                        quo_d    = '1;
                        rem_d    = a_i;
                        result_d = is_q_i ? '1 : a_i;
                        state_d  = DIV_DONE;
                    end else begin
                        quo_d   = a_i;
                        rem_d   = '0;
                        state_d = DIV_BUSY;
                    end
                end
            end
            DIV_BUSY: begin
                if (!req_i) begin
                    state_d = DIV_IDLE;
                end else begin
                    quo_d = quo_n;
                    rem_d = rem_n;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_d = sel_q ? quo_n : rem_n;
                        state_d  = DIV_DONE;
                    end
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            sel_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            div_q    <= div_d;
            sel_q    <= sel_d;
            result_q <= result_d;
        end
    end

    assign ready_o  = (state_q == DIV_DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected result and ready cycle queued at issue, checked on ready_o.
module tb_div_iter;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic [31:0] a, b;
    logic        isq;
    logic        ready;
    logic [31:0] result;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    logic prev_rdy = 1'b0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       tag;
    } exp_t;
    exp_t sb[$];

    div_iter #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .req_i    (req),
        .a_i      (a),
        .b_i      (b),
        .is_q_i   (isq),
        .ready_o  (ready),
        .result_o (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ready_o must never stay high two cycles running
    always @(negedge clk) begin
        if (ready) chk("rdy_twice", {31'b0, prev_rdy}, 32'd0);
        prev_rdy = ready;
    end

    // now=1: called in the DONE cycle, request stays high so the accept is the next cycle
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic qv,
                         input string tag, input bit now);
        exp_t e;
        int   acc;
        if (!now) @(negedge clk);
        a = av; b = bv; isq = qv; req = 1'b1;
        acc = now ? cyc + 1 : cyc;
        if (bv == 0) begin
            e.res = qv ? 32'hFFFF_FFFF : av;
            e.cyc = acc + 1;
        end else begin
            e.res = qv ? av / bv : av % bv;
            e.cyc = acc + 33;
        end
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic wait_ready(input bit drop);
        exp_t e;
        bit   seen = 0;
        int   n = 0;
        while (!seen && n < 45) begin
            @(negedge clk);
            n++;
            if (ready) seen = 1;
        end
        if (!seen) begin
            chk("timeout", {31'b0, ready}, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            chk("spurious", {31'b0, ready}, 32'd0);
        end else begin
            e = sb.pop_front();
            chk(e.tag, result, e.res);
            chk({e.tag, "_lat"}, cyc, e.cyc);
        end
        if (drop) req = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; a = '0; b = '0; isq = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", {31'b0, ready}, 32'd0);
        chk("rst_res", result, 32'd0);
        rst_n = 1'b1;

        // basic quotient / remainder, then result hold
        issue(32'd100, 32'd7, 1'b1, "q100_7", 0); wait_ready(1);
        repeat (3) @(negedge clk);
        chk("hold", result, 32'd14);
        issue(32'd100, 32'd7, 1'b0, "r100_7", 0); wait_ready(1);

        // extremes
        issue(32'hFFFF_FFFF, 32'd1, 1'b1, "qmax_1", 0);          wait_ready(1);
        issue(32'd5, 32'hFFFF_FFFF, 1'b0, "r5_max", 0);          wait_ready(1);
        issue(32'd5, 32'hFFFF_FFFF, 1'b1, "q5_max", 0);          wait_ready(1);

        // divide by zero
        issue(32'h1234_5678, 32'd0, 1'b1, "qdiv0", 0);           wait_ready(1);
        issue(32'h1234_5678, 32'd0, 1'b0, "rdiv0", 0);           wait_ready(1);

        // operands change after accept
        issue(32'd200, 32'd9, 1'b1, "opchg", 0);
        @(negedge clk);
        a = 32'hFFFF_FFFF; b = 32'd1; isq = 1'b0;
        wait_ready(1);

        // abort mid-BUSY, then full-latency request
        issue(32'd50, 32'd5, 1'b1, "abort", 0);
        void'(sb.pop_back());
        repeat (11) @(negedge clk);
        req = 1'b0;
        repeat (40) begin
            @(negedge clk);
            chk("abort_rdy", {31'b0, ready}, 32'd0);
        end
        issue(32'd9, 32'd3, 1'b1, "q9_3", 0);                    wait_ready(1);

        // back-to-back: request held across DONE with new operands
        issue(32'd50, 32'd5, 1'b1, "b2b_1", 0);                  wait_ready(0);
        issue(32'd81, 32'd9, 1'b1, "b2b_2", 1);                  wait_ready(1);

        // reset mid-BUSY
        issue(32'd100, 32'd7, 1'b1, "rstbusy", 0);
        repeat (6) @(negedge clk);
        rst_n = 1'b0; req = 1'b0;
        sb.delete();
        #1;
        chk("rstb_rdy", {31'b0, ready}, 32'd0);
        chk("rstb_res", result, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("rstb_rdy_hold", {31'b0, ready}, 32'd0);
        end
        rst_n = 1'b1;
        issue(32'd10, 32'd3, 1'b0, "r10_3", 0);                  wait_ready(1);

        // random operands, including a<b and a==b
        for (int i = 0; i < 8; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 1000);
                2: rb = ra;
                default: rb = ra + 32'd1;
            endcase
            if (rb == 0) rb = 32'd3;
            issue(ra, rb, i[0], $sformatf("rnd%0d", i), 0);
            wait_ready(1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
